// File: rtl/kugelblitz_pkg.sv
// Shared constants and offset helpers for the kugelblitz stream stages.
// Byte offsets are split into a beat number and a byte lane within a 64-byte beat.
package kugelblitz_pkg;

  localparam int KG_BEAT_BYTES   = 64;
  localparam int KG_LANE_BITS    = 6;
  localparam int KG_OFFSET_MAX_W = 16;

  function automatic logic [KG_OFFSET_MAX_W-1:0] kg_beat_of(input logic [KG_OFFSET_MAX_W-1:0] offset);
    return offset >> KG_LANE_BITS;
  endfunction

  function automatic logic [KG_LANE_BITS-1:0] kg_lane_of(input logic [KG_OFFSET_MAX_W-1:0] offset);
    return offset[KG_LANE_BITS-1:0];
  endfunction

endpackage

// File: rtl/kg_axis_skid.sv
// Generic two-entry register slice: output register plus skid register.
// Valid/ready: a word moves when valid and ready are both high; s_ready_o is registered and means "skid empty".
module kg_axis_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             ready_q, ready_d;
  logic             accept;

  assign accept = s_valid_i & ready_q;

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || m_ready_i) begin
      // Skid contents are always older than anything arriving now.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_data_d  = s_data_i;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d  = s_data_i;
      skid_valid_d = 1'b1;
    end
    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign s_ready_o = ready_q;
  assign m_data_o  = out_data_q;
  assign m_valid_o = out_valid_q;

endmodule

// File: rtl/kugelblitz_frame_patch.sv
// Overwrites one byte at an absolute frame offset and keeps saturating per-frame statistics.
// Config is latched on the first beat of each frame; output is registered through kg_axis_skid.
module kugelblitz_frame_patch
  import kugelblitz_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int USER_WIDTH      = 1,
  parameter int OFFSET_WIDTH    = 14,
  parameter int STAT_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic [USER_WIDTH-1:0]      s_axis_tuser,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [USER_WIDTH-1:0]      m_axis_tuser,
  input  logic                       cfg_patch_enable,
  input  logic [OFFSET_WIDTH-1:0]    cfg_patch_offset,
  input  logic [7:0]                 cfg_patch_data,
  output logic [STAT_WIDTH-1:0]      stat_frame_count,
  output logic [STAT_WIDTH-1:0]      stat_patch_count,
  output logic [STAT_WIDTH-1:0]      stat_short_count
);

  localparam int BEAT_W = OFFSET_WIDTH - KG_LANE_BITS;
  localparam int REC_W  = AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH + 1 + USER_WIDTH;

  if (AXIS_DATA_WIDTH != 512) begin : g_bad_data_width
    $error("kugelblitz_frame_patch supports only AXIS_DATA_WIDTH = 512");
  end
  if (AXIS_KEEP_WIDTH != AXIS_DATA_WIDTH / 8) begin : g_bad_keep_width
    $error("kugelblitz_frame_patch requires AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8");
  end
  if (OFFSET_WIDTH <= KG_LANE_BITS || OFFSET_WIDTH > KG_OFFSET_MAX_W) begin : g_bad_offset_width
    $error("kugelblitz_frame_patch OFFSET_WIDTH out of range");
  end

  logic                    in_frame_q, in_frame_d;
  logic [BEAT_W-1:0]       beat_idx_q, beat_idx_d;
  logic                    patched_q, patched_d;
  logic                    lat_en_q, lat_en_d;
  logic [OFFSET_WIDTH-1:0] lat_off_q, lat_off_d;
  logic [7:0]              lat_data_q, lat_data_d;
  logic [STAT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
  logic [STAT_WIDTH-1:0]   patch_cnt_q, patch_cnt_d;
  logic [STAT_WIDTH-1:0]   short_cnt_q, short_cnt_d;

  logic                       accept;
  logic                       eff_en;
  logic [OFFSET_WIDTH-1:0]    eff_off;
  logic [7:0]                 eff_data;
  logic [KG_OFFSET_MAX_W-1:0] tgt_beat;
  logic [KG_LANE_BITS-1:0]    tgt_lane;
  logic                       hit;
  logic [AXIS_DATA_WIDTH-1:0] patched_data;
  logic [REC_W-1:0]           skid_in, skid_out;

  assign accept = s_axis_tvalid & s_axis_tready;

  // The first beat of a frame uses the live config so single-beat frames can be patched.
  assign eff_en   = in_frame_q ? lat_en_q   : cfg_patch_enable;
  assign eff_off  = in_frame_q ? lat_off_q  : cfg_patch_offset;
  assign eff_data = in_frame_q ? lat_data_q : cfg_patch_data;
  assign tgt_beat = kg_beat_of(KG_OFFSET_MAX_W'(eff_off));
  assign tgt_lane = kg_lane_of(KG_OFFSET_MAX_W'(eff_off));
  assign hit      = accept & eff_en & s_axis_tkeep[tgt_lane]
                  & (KG_OFFSET_MAX_W'(beat_idx_q) == tgt_beat);

  always_comb begin
    patched_data = s_axis_tdata;
    if (hit) patched_data[{tgt_lane, 3'b000} +: 8] = eff_data;
  end

  always_comb begin
    in_frame_d  = in_frame_q;
    beat_idx_d  = beat_idx_q;
    patched_d   = patched_q;
    lat_en_d    = lat_en_q;
    lat_off_d   = lat_off_q;
    lat_data_d  = lat_data_q;
    frame_cnt_d = frame_cnt_q;
    patch_cnt_d = patch_cnt_q;
    short_cnt_d = short_cnt_q;
    if (accept) begin
      if (!in_frame_q) begin
        lat_en_d   = cfg_patch_enable;
        lat_off_d  = cfg_patch_offset;
        lat_data_d = cfg_patch_data;
      end
      if (s_axis_tlast) begin
        in_frame_d = 1'b0;
        beat_idx_d = '0;
        patched_d  = 1'b0;
        if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 1'b1;
        if (patched_q || hit) begin
          if (patch_cnt_q != '1) patch_cnt_d = patch_cnt_q + 1'b1;
        end else if (eff_en) begin
          if (short_cnt_q != '1) short_cnt_d = short_cnt_q + 1'b1;
        end
      end else begin
        in_frame_d = 1'b1;
        patched_d  = patched_q | hit;
        if (beat_idx_q != '1) beat_idx_d = beat_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame_q  <= 1'b0;
      beat_idx_q  <= '0;
      patched_q   <= 1'b0;
      lat_en_q    <= 1'b0;
      lat_off_q   <= '0;
      lat_data_q  <= '0;
      frame_cnt_q <= '0;
      patch_cnt_q <= '0;
      short_cnt_q <= '0;
    end else begin
      in_frame_q  <= in_frame_d;
      beat_idx_q  <= beat_idx_d;
      patched_q   <= patched_d;
      lat_en_q    <= lat_en_d;
      lat_off_q   <= lat_off_d;
      lat_data_q  <= lat_data_d;
      frame_cnt_q <= frame_cnt_d;
      patch_cnt_q <= patch_cnt_d;
      short_cnt_q <= short_cnt_d;
    end
  end

  assign skid_in = {patched_data, s_axis_tkeep, s_axis_tlast, s_axis_tuser};

  kg_axis_skid #(.WIDTH(REC_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (skid_in),
    .s_valid_i (s_axis_tvalid),
    .s_ready_o (s_axis_tready),
    .m_data_o  (skid_out),
    .m_valid_o (m_axis_tvalid),
    .m_ready_i (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = skid_out;

  assign stat_frame_count = frame_cnt_q;
  assign stat_patch_count = patch_cnt_q;
  assign stat_short_count = short_cnt_q;

endmodule

// File: tb/tb_kugelblitz_frame_patch.sv
// Bench for kugelblitz_frame_patch: directed frame table, config/reset corner sequences,
// and a random-backpressure run, all checked against an expected-beat queue.
module tb_kugelblitz_frame_patch;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int UW = 1;
  localparam int OW = 14;
  localparam int SW = 32;
  localparam int RW = DW + KW + 1 + UW;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [UW-1:0] s_axis_tuser;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [UW-1:0] m_axis_tuser;
  logic          cfg_patch_enable;
  logic [OW-1:0] cfg_patch_offset;
  logic [7:0]    cfg_patch_data;
  logic [SW-1:0] stat_frame_count;
  logic [SW-1:0] stat_patch_count;
  logic [SW-1:0] stat_short_count;

  kugelblitz_frame_patch #(
    .AXIS_DATA_WIDTH (DW),
    .AXIS_KEEP_WIDTH (KW),
    .USER_WIDTH      (UW),
    .OFFSET_WIDTH    (OW),
    .STAT_WIDTH      (SW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tuser     (s_axis_tuser),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .cfg_patch_enable (cfg_patch_enable),
    .cfg_patch_offset (cfg_patch_offset),
    .cfg_patch_data   (cfg_patch_data),
    .stat_frame_count (stat_frame_count),
    .stat_patch_count (stat_patch_count),
    .stat_short_count (stat_short_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [RW-1:0] exp_q[$];
  int          lat_q[$];
  int          occ      = 0;
  bit          occ_chk  = 0;
  bit          lat_chk  = 1;
  bit          rand_rdy = 0;
  longint      exp_frame = 0;
  longint      exp_patch = 0;
  longint      exp_short = 0;

  typedef struct {
    logic          en;
    logic [OW-1:0] off;
    logic [7:0]    pd;
    int            n;
    int            clr;
    int            mid;
    int            pinc;
    int            sinc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd512();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Output monitor: samples at negedge what will transfer at the next posedge.
  logic [RW-1:0] mon_got;
  logic [RW-1:0] mon_want;
  int            mon_t;
  always @(negedge clk) begin
    if (rst_n) begin
      if (occ_chk) chk("tready_vs_skid", 64'(s_axis_tready), 64'(occ != 2));
      if (m_axis_tvalid && m_axis_tready) begin
        mon_got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_beat: got unexpected beat %0h, expected none", mon_got);
        end else begin
          mon_want = exp_q.pop_front();
          mon_t    = lat_q.pop_front();
          if (mon_got !== mon_want) begin
            n_fail++;
            $display("FAIL out_beat: got %0h expected %0h", mon_got, mon_want);
          end
          if (lat_chk) chk("latency", 64'(cyc - mon_t), 64'd1);
        end
      end
      occ = occ + int'(s_axis_tvalid && s_axis_tready) - int'(m_axis_tvalid && m_axis_tready);
    end
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                           input logic [UW-1:0] u, input logic [RW-1:0] e);
    bit done = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        exp_q.push_back(e);
        lat_q.push_back(cyc);
        done = 1;
      end
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no s_axis_tready in 1000 cycles, expected acceptance");
    end
  endtask

  task automatic run_frame(input int n, input logic en, input logic [OW-1:0] off, input logic [7:0] pd,
                           input int clr_lane, input int mid_pd, output bit pat);
    logic [DW-1:0] d;
    logic [DW-1:0] ed;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
    int            tb;
    int            tl;
    tb = int'(off >> 6);
    tl = int'(off[5:0]);
    cfg_patch_enable = en;
    cfg_patch_offset = off;
    cfg_patch_data   = pd;
    pat = 0;
    for (int b = 0; b < n; b++) begin
      d  = rnd512();
      k  = '1;
      u  = UW'($urandom_range(0, 1));
      l  = (b == n - 1);
      if (clr_lane >= 0 && b == tb) k[clr_lane] = 1'b0;
      ed = d;
      if (en && b == tb && k[tl]) begin
        ed[tl*8 +: 8] = pd;
        pat = 1;
      end
      send_beat(d, k, l, u, {ed, k, l, u});
      if (b == 0 && mid_pd >= 0) cfg_patch_data = mid_pd[7:0];
      if (rand_rdy && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_frame_count"}, 64'(stat_frame_count), 64'(exp_frame));
    chk({tag, "_patch_count"}, 64'(stat_patch_count), 64'(exp_patch));
    chk({tag, "_short_count"}, 64'(stat_short_count), 64'(exp_short));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit            pat;
    logic [DW-1:0] d;
    int            n;
    logic          en;
    logic [OW-1:0] off;
    logic [7:0]    pd;
    int            clr;

    vecs[0] = '{1'b1, 14'd5,     8'hAA, 3, -1, -1,    1, 0};
    vecs[1] = '{1'b1, 14'd130,   8'h5C, 4, -1, -1,    1, 0};
    vecs[2] = '{1'b1, 14'd200,   8'h3E, 2, -1, -1,    0, 1};
    vecs[3] = '{1'b1, 14'd3,     8'hC3, 1,  3, -1,    0, 1};
    vecs[4] = '{1'b1, 14'd68,    8'h11, 2, -1, 8'h22, 1, 0};
    vecs[5] = '{1'b1, 14'd68,    8'h22, 2, -1, -1,    1, 0};
    vecs[6] = '{1'b0, 14'd10,    8'hF0, 3, -1, -1,    0, 0};
    vecs[7] = '{1'b1, 14'd63,    8'h81, 1, -1, -1,    1, 0};
    vecs[8] = '{1'b1, 14'd16383, 8'h42, 2, -1, -1,    0, 1};
    vecs[9] = '{1'b1, 14'd64,    8'h0F, 2, -1, -1,    1, 0};

    rst_n            = 1'b0;
    s_axis_tdata     = '0;
    s_axis_tkeep     = '0;
    s_axis_tvalid    = 1'b0;
    s_axis_tlast     = 1'b0;
    s_axis_tuser     = '0;
    cfg_patch_enable = 1'b0;
    cfg_patch_offset = '0;
    cfg_patch_data   = '0;

    #12;
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_m_tdata_nonzero", 64'(|m_axis_tdata), 64'd0);
    chk("rst_m_tkeep", 64'(m_axis_tkeep), 64'd0);
    chk("rst_m_tlast_tuser", 64'({m_axis_tlast, m_axis_tuser}), 64'd0);
    check_stats("rst");
    #10;
    rst_n = 1'b1;
    #2;
    chk("tready_before_edge", 64'(s_axis_tready), 64'd0);
    @(negedge clk);
    chk("tready_after_edge", 64'(s_axis_tready), 64'd1);
    @(posedge clk);
    #1;

    for (int v = 0; v < 10; v++) begin
      run_frame(vecs[v].n, vecs[v].en, vecs[v].off, vecs[v].pd, vecs[v].clr, vecs[v].mid, pat);
      exp_frame += 1;
      exp_patch += vecs[v].pinc;
      exp_short += vecs[v].sinc;
      wait_drain();
      check_stats($sformatf("vec%0d", v));
    end

    // Partial frame, then asynchronous reset mid-frame.
    cfg_patch_enable = 1'b1;
    cfg_patch_offset = 14'd70;
    cfg_patch_data   = 8'h99;
    d = rnd512();
    send_beat(d, '1, 1'b0, '0, {d, {KW{1'b1}}, 1'b0, {UW{1'b0}}});
    wait_drain();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("midrst_m_tdata_nonzero", 64'(|m_axis_tdata), 64'd0);
    exp_q.delete();
    lat_q.delete();
    occ = 0;
    exp_frame = 0;
    exp_patch = 0;
    exp_short = 0;
    check_stats("midrst");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(2, 1'b1, 14'd2, 8'h77, -1, -1, pat);
    exp_frame = 1;
    exp_patch = 1;
    wait_drain();
    check_stats("postrst");

    // Random backpressure across 100 frames.
    rand_rdy = 1;
    lat_chk  = 0;
    occ_chk  = 1;
    for (int f = 0; f < 100; f++) begin
      n   = $urandom_range(1, 20);
      en  = ($urandom_range(0, 3) != 0);
      off = OW'($urandom_range(0, 1400));
      pd  = 8'($urandom_range(0, 255));
      clr = ($urandom_range(0, 7) == 0) ? int'(off[5:0]) : -1;
      run_frame(n, en, off, pd, clr, -1, pat);
      exp_frame += 1;
      if (pat) exp_patch += 1;
      else if (en) exp_short += 1;
    end
    wait_drain();
    occ_chk = 0;
    check_stats("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of test, expected finish within 2 ms");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/kugelblitz_frame_patch.md
Name: kugelblitz_frame_patch

Overview:
Per-port AXI-Stream stage placed directly downstream of the kugelblitz offload stage, one instance per port on both the TX and RX paths. It overwrites one byte at a programmable absolute frame byte offset, so patches can land beyond the first 64-byte beat. The output is registered and backed by a skid buffer, so the stage sustains full throughput. It also keeps saturating per-frame statistics.

Parameters:
AXIS_DATA_WIDTH, 512, stream data width; only 512 is supported, any other value is an elaboration error.
AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width; must equal AXIS_DATA_WIDTH/8.
USER_WIDTH, 1, tuser width; passed through unmodified.
OFFSET_WIDTH, 14, width of the byte-offset configuration (16 KiB frame reach).
STAT_WIDTH, 32, width of each statistics counter.

Ports:
clk  in  1  stage clock.
rst_n  in  1  reset, asynchronous assert, active low.
s_axis_tdata  in  AXIS_DATA_WIDTH  input data.
s_axis_tkeep  in  AXIS_KEEP_WIDTH  input byte enables.
s_axis_tvalid  in  1  input valid.
s_axis_tready  out  1  input ready.
s_axis_tlast  in  1  end of frame.
s_axis_tuser  in  USER_WIDTH  sideband, passed through.
m_axis_tdata  out  AXIS_DATA_WIDTH  output data.
m_axis_tkeep  out  AXIS_KEEP_WIDTH  output byte enables.
m_axis_tvalid  out  1  output valid.
m_axis_tready  in  1  output ready.
m_axis_tlast  out  1  end of frame.
m_axis_tuser  out  USER_WIDTH  sideband.
cfg_patch_enable  in  1  enable patching.
cfg_patch_offset  in  OFFSET_WIDTH  absolute byte offset within the frame.
cfg_patch_data  in  8  replacement byte.
stat_frame_count  out  STAT_WIDTH  frames accepted (tlast handshakes).
stat_patch_count  out  STAT_WIDTH  frames in which the patch was applied.
stat_short_count  out  STAT_WIDTH  enabled frames that ended before the offset was reached, or whose target lane had tkeep=0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. On assertion: m_axis_tvalid=0, s_axis_tready=0, m_axis_tdata/tkeep/tlast/tuser=0, all stat counters=0, skid buffer empty, beat index=0, in_frame=0. s_axis_tready rises on the first clk edge after rst_n deasserts.
- Handshake: a beat transfers when valid and ready are both 1. m_axis_tvalid does not depend combinationally on m_axis_tready. s_axis_tready is registered and equals "skid buffer empty".
- Latency and throughput: 1 cycle from input handshake to m_axis_tvalid. Back-to-back beats at 100% throughput while m_axis_tready=1.
- Skid buffer: two stages, output register plus skid register.
  - Output stalled and a beat arrives: the beat goes to the skid register and s_axis_tready drops next cycle.
  - Output drains: the skid contents move to the output register and s_axis_tready returns.
  - Order is preserved. No beat is dropped or duplicated.
- Config latch:
  - On the first accepted beat of a frame (in_frame=0), cfg_* is sampled and used for that beat.
  - The sampled values are held in registers for the remaining beats.
  - Changing cfg mid-frame has no effect until the next frame.
- Beat index and lane:
  - The beat index starts at 0 on the first beat, increments per accepted beat, saturates at all-ones, and clears on the tlast handshake.
  - The target beat is offset[OFFSET_WIDTH-1:6]; the target lane is offset[5:0].
- Patch rule: on the accepted beat with beat index equal to the target beat, lane equal to the target lane, and tkeep[lane]=1, byte lane is replaced by the latched data. All other bytes, tkeep, tlast and tuser pass unchanged.
  - The patch is applied before the skid register, so skid and output contents are already patched.
- Per-frame flags:
  - patched sets on the patch beat.
  - On the tlast handshake: stat_frame_count increments.
  - If patched, stat_patch_count increments.
  - Else if the latched enable=1, stat_short_count increments.
  - Flags clear at tlast.
  - A single-beat frame is both first and last; the config is sampled and applied on the same beat.
- Counters: all stat counters saturate at all-ones and never wrap.
- Reset mid-frame: all state is discarded. The first beat accepted after reset is treated as a frame start.

Decomposition:
- Shared package kugelblitz_pkg:
  - KG_BEAT_BYTES=64, KG_LANE_BITS=6.
  - Function kg_beat_of(offset) returning offset>>KG_LANE_BITS.
  - Function kg_lane_of(offset) returning offset[KG_LANE_BITS-1:0].
- Sub-module kg_axis_skid: generic 2-entry register slice with the same async active-low reset. It is reused elsewhere in the kugelblitz path.
- The patch logic, config latch and counters stay in this module.

Test Plan:
- Offset 5, data 0xAA, enable=1, 3-beat frame, tready=1 -> byte 5 of beat 0 is 0xAA, all else unchanged, 1-cycle latency; patch_count=1, frame_count=1.
- Offset 130 (beat 2, lane 2), data 0x5C, 4-beat frame -> only byte 2 of beat 2 changes; beats 0, 1 and 3 are bit-identical.
- Offset 200, 2-beat frame -> no byte modified; short_count=1, patch_count=0. Offset 3 with tkeep[3]=0 -> no patch; short_count=2.
- cfg_patch_data changes from 0x11 to 0x22 after beat 0 of a frame targeting beat 1 -> output shows 0x11; the next frame shows 0x22.
- Random m_axis_tready at 50% across 100 frames with random lengths 1-20 beats -> output stream equals the reference model, no loss or reordering; s_axis_tready low only while the skid register is full.
- rst_n pulsed low asynchronously mid-frame -> outputs and counters zero immediately; the next accepted beat is treated as a frame start and patched per the current cfg.
